sys_bus_arbiter: RTL and testbench

// Round-robin arbiter granting the shared system bus to the three request-based

---
 rtl/sys_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_sys_bus_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter for the shared system bus: SPI, DMEM and DMA masters.
// Grants are held for the full transaction with a one-cycle gap between owners.
module sys_bus_arbiter #(
   parameter int HOLD_MAX = 1024,
   parameter int CNT_W    = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_req_spi,
   input  logic       i_req_dmem,
   input  logic       i_req_dma,
   output logic       o_gnt_spi,
   output logic       o_gnt_dmem,
   output logic       o_gnt_dma,
   output logic [1:0] o_sel,
   output logic       o_busy,
   output logic       o_hold_err
);

   typedef enum logic [2:0] {
      IDLE,
      OWN_SPI,
      OWN_DMEM,
      OWN_DMA,
      GAP
   } state_t;

   localparam logic [1:0] SEL_NONE = 2'd0;
   localparam logic [1:0] SEL_SPI  = 2'd1;
   localparam logic [1:0] SEL_DMEM = 2'd2;
   localparam logic [1:0] SEL_DMA  = 2'd3;

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

   state_t           state;
   state_t           next_state;
   state_t           rr_pick;
   logic [1:0]       last_owner;
   logic [CNT_W-1:0] hold_cnt;
   logic             hold_err;
   logic             owning;
   logic             entering;
   logic             staying;

   assign owning   = (state == OWN_SPI) || (state == OWN_DMEM) || (state == OWN_DMA);
   assign entering = !owning && (rr_pick != IDLE);
   assign staying  = owning && (next_state == state);

   // Search starts just after the last owner, so a master that just released loses ties
   always_comb begin
      rr_pick = IDLE;
      case (last_owner)
         SEL_SPI: begin
            if (i_req_dmem)      rr_pick = OWN_DMEM;
            else if (i_req_dma)  rr_pick = OWN_DMA;
            else if (i_req_spi)  rr_pick = OWN_SPI;
         end
         SEL_DMEM: begin
            if (i_req_dma)       rr_pick = OWN_DMA;
            else if (i_req_spi)  rr_pick = OWN_SPI;
            else if (i_req_dmem) rr_pick = OWN_DMEM;
         end
         default: begin
            if (i_req_spi)       rr_pick = OWN_SPI;
            else if (i_req_dmem) rr_pick = OWN_DMEM;
            else if (i_req_dma)  rr_pick = OWN_DMA;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE, GAP: next_state = rr_pick;
         OWN_SPI:   if (!i_req_spi)  next_state = GAP;
         OWN_DMEM:  if (!i_req_dmem) next_state = GAP;
         OWN_DMA:   if (!i_req_dma)  next_state = GAP;
         default:   next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_owner <= SEL_DMA;
      end else if (owning && next_state == GAP) begin
         case (state)
            OWN_SPI:  last_owner <= SEL_SPI;
            OWN_DMEM: last_owner <= SEL_DMEM;
            default:  last_owner <= SEL_DMA;
         endcase
      end
   end

   // hold_cnt equals the number of cycles the current grant has been visible
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_cnt <= '0;
         hold_err <= 1'b0;
      end else if (entering) begin
         hold_cnt <= CNT_W'(1);
      end else if (staying) begin
         if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
         if (hold_cnt >= HOLD_LIM) hold_err <= 1'b1;
      end else if (!owning) begin
         hold_cnt <= '0;
      end
   end

   always_comb begin
      o_gnt_spi  = 1'b0;
      o_gnt_dmem = 1'b0;
      o_gnt_dma  = 1'b0;
      o_sel      = SEL_NONE;
      case (state)
         OWN_SPI: begin
            o_gnt_spi = 1'b1;
            o_sel     = SEL_SPI;
         end
         OWN_DMEM: begin
            o_gnt_dmem = 1'b1;
            o_sel      = SEL_DMEM;
         end
         OWN_DMA: begin
            o_gnt_dma = 1'b1;
            o_sel     = SEL_DMA;
         end
         default: ;
      endcase
      o_busy     = owning;
      o_hold_err = hold_err;
   end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Scoreboard bench for sys_bus_arbiter: a cycle-level owner/pointer model
// predicts each cycle's outputs, and a monitor compares them at the falling edge.
module tb_sys_bus_arbiter;

   localparam int HOLD_MAX = 8;

   typedef struct packed {
      logic [2:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       err;
   } obs_t;

   logic       i_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_spi = 1'b0;
   logic       req_dmem = 1'b0;
   logic       req_dma = 1'b0;
   logic       gnt_spi, gnt_dmem, gnt_dma;
   logic [1:0] sel;
   logic       busy, hold_err;

   int   num_checks = 0;
   int   num_errors = 0;
   obs_t exp_q[$];

   int   m_owner = 0;
   int   m_last  = 3;
   int   m_held  = 0;
   logic m_err   = 1'b0;

   sys_bus_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(16)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (rst_n),
      .i_req_spi  (req_spi),
      .i_req_dmem (req_dmem),
      .i_req_dma  (req_dma),
      .o_gnt_spi  (gnt_spi),
      .o_gnt_dmem (gnt_dmem),
      .o_gnt_dma  (gnt_dma),
      .o_sel      (sel),
      .o_busy     (busy),
      .o_hold_err (hold_err)
   );

   always #5 i_clk = ~i_clk;

   function automatic obs_t actual();
      obs_t a;
      a.gnt  = {gnt_dma, gnt_dmem, gnt_spi};
      a.sel  = sel;
      a.busy = busy;
      a.err  = hold_err;
      return a;
   endfunction

   task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
      num_checks++;
      if (act !== exp) begin
         num_errors++;
         $display("[TB] FAIL %s @%0t: got gnt=%b sel=%0d busy=%b err=%b, expected gnt=%b sel=%0d busy=%b err=%b",
                  name, $time, act.gnt, act.sel, act.busy, act.err,
                  exp.gnt, exp.sel, exp.busy, exp.err);
      end
   endtask

   // Reference model: master 1=SPI 2=DMEM 3=DMA; an empty owner slot after a release is the gap
   initial forever begin
      logic [2:0] rv;
      obs_t       e;
      @(posedge i_clk or negedge rst_n);
      if (!rst_n) begin
         m_owner = 0;
         m_last  = 3;
         m_held  = 0;
         m_err   = 1'b0;
      end else begin
         rv = {req_dma, req_dmem, req_spi};
         if (m_owner != 0) begin
            if (rv[m_owner-1]) begin
               m_held++;
               if (m_held > HOLD_MAX) m_err = 1'b1;
            end else begin
               m_last  = m_owner;
               m_owner = 0;
            end
         end else begin
            for (int i = 1; i <= 3; i++) begin
               int c;
               c = (m_last - 1 + i) % 3 + 1;
               if (m_owner == 0 && rv[c-1]) begin
                  m_owner = c;
                  m_held  = 1;
               end
            end
         end
         e.gnt  = (m_owner == 0) ? 3'b000 : 3'(1 << (m_owner - 1));
         e.sel  = 2'(m_owner);
         e.busy = (m_owner != 0);
         e.err  = m_err;
         exp_q.push_back(e);
      end
   end

   initial forever begin
      obs_t e;
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("scoreboard", actual(), e);
      end
   end

   task automatic applyStimulus(input logic [2:0] v, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge i_clk);
         {req_dma, req_dmem, req_spi} = v;
      end
   endtask

   task automatic pulseReset();
      @(negedge i_clk);
      #2 rst_n = 1'b0;
      #1 checkOutput("async_reset", actual(), '0);
      @(negedge i_clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      logic [2:0] rv;
      $display("[TB] start");
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         checkOutput("reset_hold", actual(), '0);
      end
      #2 rst_n = 1'b1;

      applyStimulus(3'b000, 10);
      applyStimulus(3'b010, 5);
      applyStimulus(3'b000, 3);

      pulseReset();
      applyStimulus(3'b111, 3);
      applyStimulus(3'b110, 4);
      applyStimulus(3'b100, 4);
      applyStimulus(3'b000, 3);

      applyStimulus(3'b100, 2);
      applyStimulus(3'b111, 3);
      applyStimulus(3'b011, 4);
      applyStimulus(3'b010, 4);
      applyStimulus(3'b000, 3);

      applyStimulus(3'b100, 20);
      applyStimulus(3'b000, 4);

      applyStimulus(3'b001, 2);
      #2 checkOutput("pre_reset_gnt", actual(), '{gnt: 3'b001, sel: 2'd1, busy: 1'b1, err: 1'b1});
      rst_n = 1'b0;
      #1 checkOutput("async_reset_mid_grant", actual(), '0);
      @(negedge i_clk);
      #2 rst_n = 1'b1;
      applyStimulus(3'b011, 3);
      applyStimulus(3'b010, 3);
      applyStimulus(3'b000, 3);

      pulseReset();
      rv = 3'b000;
      for (int k = 0; k < 400; k++) begin
         for (int b = 0; b < 3; b++) begin
            if (rv[b]) rv[b] = ($urandom_range(0, 3) != 0);
            else       rv[b] = ($urandom_range(0, 2) == 0);
         end
         applyStimulus(rv, 1);
      end
      applyStimulus(3'b000, 5);
      @(negedge i_clk);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
